// File: rtl/as_gpio_ctrl_pkg.sv
// rtl/as_gpio_ctrl_pkg.sv - shared sizes, register offsets and FSM state type for the GPIO controller
package as_gpio_ctrl_pkg;

  localparam int nr_gpios        = 32;
  localparam int gpio_addr_width = 8;

  localparam int GPIO_OFS_DOUT = 'h00;
  localparam int GPIO_OFS_DIR  = 'h08;
  localparam int GPIO_OFS_DIN  = 'h10;
  localparam int GPIO_OFS_IMSK = 'h18;
  localparam int GPIO_OFS_IPND = 'h20;

  typedef enum logic [1:0] {GS_IDLE, GS_ACC, GS_REL} gpio_state_t;

endpackage

// File: rtl/as_gpio_ctrl_if.sv
// rtl/as_gpio_ctrl_if.sv - req/ack register bus between the core data port and the GPIO controller
interface as_gpio_ctrl_if
  import as_gpio_ctrl_pkg::*;
#(
  parameter int AW = gpio_addr_width
);
  logic          req_i;
  logic          we_i;
  logic [AW-1:0] addr_i;
  logic [63:0]   wdata_i;
  logic [63:0]   rdata_o;
  logic          ack_o;

  modport master (output req_i, we_i, addr_i, wdata_i, input rdata_o, ack_o);
  modport slave  (input req_i, we_i, addr_i, wdata_i, output rdata_o, ack_o);
endinterface

// File: rtl/as_gpio_ctrl_sync.sv
// rtl/as_gpio_ctrl_sync.sv - NGPIO-wide, SYNC_FF-deep flop-chain input synchronizer
module as_gpio_ctrl_sync #(
  parameter int NGPIO   = 32,
  parameter int SYNC_FF = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NGPIO-1:0] d,
  output logic [NGPIO-1:0] q
);
  logic [SYNC_FF-1:0][NGPIO-1:0] chain;

  always_ff @(posedge clk_i) begin
    if (rst_i) chain <= '0;
    else       chain <= {chain[SYNC_FF-2:0], d};
  end

  assign q = chain[SYNC_FF-1];
endmodule

// File: rtl/as_gpio_ctrl.sv
// rtl/as_gpio_ctrl.sv - memory-mapped GPIO controller; GPIO_IRQ_EN adds edge-triggered pending/mask interrupt
module as_gpio_ctrl
  import as_gpio_ctrl_pkg::*;
#(
  parameter int NGPIO   = nr_gpios,
  parameter int AW      = gpio_addr_width,
  parameter int SYNC_FF = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  as_gpio_ctrl_if.slave    bus,
  inout  wire [NGPIO-1:0]  gpio_io,
  output logic             cs_o,
  output logic             irq_o
);
  gpio_state_t      state;
  logic [NGPIO-1:0] dout;
  logic [NGPIO-1:0] dir;
  logic [NGPIO-1:0] din;
  logic [NGPIO-1:0] imsk;
  logic [NGPIO-1:0] ipnd;
  logic [AW-1:0]    ofs;
  logic [63:0]      rd_val;
  logic             wr_go;
  logic             unused_bits;

  assign ofs         = {bus.addr_i[AW-1:3], 3'b000};
  assign wr_go       = (state == GS_IDLE) && bus.req_i && bus.we_i;
  assign unused_bits = ^{bus.addr_i[2:0], bus.wdata_i};

  for (genvar i = 0; i < NGPIO; i++) begin : g_pin
    assign gpio_io[i] = dir[i] ? dout[i] : 1'bz;
  end

  as_gpio_ctrl_sync #(.NGPIO(NGPIO), .SYNC_FF(SYNC_FF)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (gpio_io),
    .q     (din)
  );

  always_comb begin
    rd_val = '0;
    case (ofs)
      AW'(GPIO_OFS_DOUT): rd_val[NGPIO-1:0] = dout;
      AW'(GPIO_OFS_DIR):  rd_val[NGPIO-1:0] = dir;
      AW'(GPIO_OFS_DIN):  rd_val[NGPIO-1:0] = din;
      AW'(GPIO_OFS_IMSK): rd_val[NGPIO-1:0] = imsk;
      AW'(GPIO_OFS_IPND): rd_val[NGPIO-1:0] = ipnd;
      default:            rd_val = '0;
    endcase
  end

  // Writes and read capture both happen on the edge leaving IDLE, so ACC only presents ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= GS_IDLE;
      bus.ack_o   <= 1'b0;
      bus.rdata_o <= '0;
      cs_o        <= 1'b0;
      dout        <= '0;
      dir         <= '0;
    end else begin
      case (state)
        GS_IDLE: begin
          if (bus.req_i) begin
            state       <= GS_ACC;
            bus.ack_o   <= 1'b1;
            bus.rdata_o <= bus.we_i ? 64'd0 : rd_val;
            cs_o        <= bus.we_i && (ofs == AW'(GPIO_OFS_DOUT));
            if (bus.we_i) begin
              if (ofs == AW'(GPIO_OFS_DOUT)) dout <= bus.wdata_i[NGPIO-1:0];
              if (ofs == AW'(GPIO_OFS_DIR))  dir  <= bus.wdata_i[NGPIO-1:0];
            end
          end
        end
        GS_ACC: begin
          state       <= GS_REL;
          bus.ack_o   <= 1'b0;
          bus.rdata_o <= '0;
          cs_o        <= 1'b0;
        end
        GS_REL: begin
          if (!bus.req_i) state <= GS_IDLE;
        end
        default: state <= GS_IDLE;
      endcase
    end
  end

`ifdef GPIO_IRQ_EN
  logic [NGPIO-1:0] din_q;
  logic [NGPIO-1:0] ipnd_clr;

  assign ipnd_clr = (wr_go && ofs == AW'(GPIO_OFS_IPND)) ? bus.wdata_i[NGPIO-1:0] : '0;

  // Set term applied after the clear so a simultaneous edge keeps the bit pending.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      din_q <= '0;
      ipnd  <= '0;
      imsk  <= '0;
      irq_o <= 1'b0;
    end else begin
      din_q <= din;
      ipnd  <= (ipnd & ~ipnd_clr) | (din & ~din_q);
      irq_o <= |(ipnd & imsk);
      if (wr_go && ofs == AW'(GPIO_OFS_IMSK)) imsk <= bus.wdata_i[NGPIO-1:0];
    end
  end
`else
  assign imsk  = '0;
  assign ipnd  = '0;
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_as_gpio_ctrl.sv
// tb/tb_as_gpio_ctrl.sv - scoreboard testbench for as_gpio_ctrl
module tb_as_gpio_ctrl;
  localparam int NG = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs;
  logic          irq;
  wire  [NG-1:0] gpio;
  logic          drv_en = 1'b0;
  logic [NG-1:0] drv_val = '0;

  assign gpio = drv_en ? drv_val : {NG{1'bz}};

  as_gpio_ctrl_if #(.AW(8)) bus ();

  as_gpio_ctrl #(.NGPIO(NG), .AW(8), .SYNC_FF(2)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .gpio_io (gpio),
    .cs_o    (cs),
    .irq_o   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        cs;
    logic [31:0] pins;
    logic [31:0] pmask;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   ack_cnt  = 0;
  int   cs_cnt   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.ack_o) begin
      ack_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_ack", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_rdata"}, bus.rdata_o, e.rdata);
        chk({e.name, "_cs"}, {63'd0, cs}, {63'd0, e.cs});
        if (e.pmask != 0) chk({e.name, "_pins"}, {32'd0, gpio & e.pmask}, {32'd0, e.pins});
      end
    end
    if (cs) begin
      cs_cnt++;
      if (!bus.ack_o) chk("cs_without_ack", 64'd1, 64'd0);
    end
  end

  task automatic access(input logic w, input logic [7:0] a, input logic [63:0] d,
                        input logic [63:0] er, input logic ecs, input logic [31:0] ep,
                        input logic [31:0] em, input int hold, input string nm);
    exp_t e;
    int   cyc;
    e.rdata = er; e.cs = ecs; e.pins = ep; e.pmask = em; e.name = nm;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.req_i = 1'b1; bus.we_i = w; bus.addr_i = a; bus.wdata_i = d;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!bus.ack_o && cyc < 8);
    chk({nm, "_latency"}, 64'(cyc), 64'd1);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    bus.req_i = 1'b0; bus.we_i = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    int a0;
    int c0;
    bit seen;
    exp_t e;
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ack", {63'd0, bus.ack_o}, 64'd0);
    chk("reset_rdata", bus.rdata_o, 64'd0);
    chk("reset_cs", {63'd0, cs}, 64'd0);
    chk("reset_irq", {63'd0, irq}, 64'd0);

    access(0, 8'h08, 0, 64'd0, 0, 0, 0, 0, "rd_dir_reset");
    access(1, 8'h08, 64'hFF, 64'd0, 0, 0, 0, 0, "wr_dir_ff");
    access(1, 8'h00, 64'h5, 64'd0, 1, 32'h05, 32'hFF, 0, "wr_dout_5");
    access(0, 8'h00, 0, 64'h5, 0, 0, 0, 0, "rd_dout_5");
    access(0, 8'h0C, 0, 64'hFF, 0, 0, 0, 0, "rd_dir_lowbits_ignored");
    access(1, 8'h00, 64'hFFFF_0000_0000_0033, 64'd0, 1, 32'h33, 32'hFF, 0, "wr_dout_wide");
    access(0, 8'h00, 0, 64'h33, 0, 0, 0, 0, "rd_dout_trunc");
    access(1, 8'h28, 64'h1234, 64'd0, 0, 0, 0, 0, "wr_unmapped");
    access(0, 8'h28, 0, 64'd0, 0, 0, 0, 0, "rd_unmapped");
    access(1, 8'h08, 64'hFFFF_FFFF, 64'd0, 0, 0, 0, 0, "wr_dir_all");
    repeat (4) @(posedge clk);
    access(0, 8'h10, 0, 64'h33, 0, 0, 0, 0, "rd_din_loopback");

    a0 = ack_cnt; c0 = cs_cnt;
    access(1, 8'h00, 64'h1, 64'd0, 1, 32'h01, 32'hFF, 4, "wr_dout_held");
    repeat (3) @(posedge clk);
    chk("held_ack_pulses", 64'(ack_cnt - a0), 64'd1);
    chk("held_cs_pulses", 64'(cs_cnt - c0), 64'd1);
    access(0, 8'h00, 0, 64'h1, 0, 0, 0, 0, "rd_after_held");

    access(1, 8'h08, 64'h0, 64'd0, 0, 0, 0, 0, "wr_dir_0");
    drv_en = 1'b1; drv_val = '0;
    repeat (4) @(posedge clk);
    #1 drv_val = 32'h8;
    access(0, 8'h10, 0, 64'h0, 0, 0, 0, 0, "rd_din_early");
    repeat (2) @(posedge clk);
    access(0, 8'h10, 0, 64'h8, 0, 0, 0, 0, "rd_din_synced");

`ifdef GPIO_IRQ_EN
    #1 drv_val = '0;
    repeat (4) @(posedge clk);
    access(1, 8'h20, 64'hFFFF_FFFF, 64'd0, 0, 0, 0, 0, "wr_ipnd_clr_all");
    access(1, 8'h18, 64'h8, 64'd0, 0, 0, 0, 0, "wr_imsk_8");
    #1 chk("irq_idle", {63'd0, irq}, 64'd0);
    drv_val = 32'h8;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(posedge clk); #1;
      seen = irq;
    end
    chk("irq_rise_within_bound", {63'd0, seen}, 64'd1);
    access(0, 8'h20, 0, 64'h8, 0, 0, 0, 0, "rd_ipnd");
    access(1, 8'h20, 64'h8, 64'd0, 0, 0, 0, 0, "wr_ipnd_clr_3");
    #1 chk("irq_cleared", {63'd0, irq}, 64'd0);
`else
    access(1, 8'h18, 64'h8, 64'd0, 0, 0, 0, 0, "wr_imsk_ignored");
    access(0, 8'h18, 0, 64'd0, 0, 0, 0, 0, "rd_imsk_zero");
    access(0, 8'h20, 0, 64'd0, 0, 0, 0, 0, "rd_ipnd_zero");
    #1 chk("irq_tied_low", {63'd0, irq}, 64'd0);
`endif

    drv_en = 1'b0;
    e.rdata = 64'd0; e.cs = 1'b1; e.pins = 0; e.pmask = 0; e.name = "wr_dout_a_reset";
    sb.push_back(e);
    @(posedge clk); #1;
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 8'h00; bus.wdata_i = 64'hA;
    @(posedge clk); #1;
    chk("rst_mid_ack_before", {63'd0, bus.ack_o}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ack_after", {63'd0, bus.ack_o}, 64'd0);
    chk("rst_mid_cs_after", {63'd0, cs}, 64'd0);
    rst = 1'b0; bus.req_i = 1'b0; bus.we_i = 1'b0;
    access(0, 8'h00, 0, 64'd0, 0, 0, 0, 0, "rd_dout_after_rst");

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
